// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared sizes and writeback-source encoding for the regfile write arbiter.
package wb_arbiter_pkg;
    localparam int AddrW = 5;
    localparam int DataW = 32;
    localparam int LongFifoDepth = 2;
    localparam int StarveMax = 4;
    typedef enum logic [1:0] {SrcNone, SrcPipe, SrcFifo, SrcBypass} wb_src_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic do_push, do_pop;
    assign empty_o = wp_q == rp_q;
    assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + (AW+1)'(do_push);
            rp_q <= rp_q + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the regfile write port, merging MEM/WB writes with buffered long-op results and tracking pending destinations.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = LongFifoDepth,
    parameter int STARVE_MAX = StarveMax
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_we,
    input  logic [AddrW-1:0] pipe_waddr,
    input  logic [DataW-1:0] pipe_wdata,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [AddrW-1:0] lu_waddr,
    input  logic [DataW-1:0] lu_wdata,
    input  logic             issue_valid,
    input  logic [AddrW-1:0] issue_addr,
    input  logic [AddrW-1:0] chk_addr1,
    input  logic [AddrW-1:0] chk_addr2,
    output logic             busy1,
    output logic             busy2,
    output logic             rf_we,
    output logic [AddrW-1:0] rf_waddr,
    output logic [DataW-1:0] rf_wdata,
    output logic             stall_req
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [31:0] pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [AddrW+DataW-1:0] head;
    logic [AddrW-1:0] lc_addr;
    logic [DataW-1:0] lc_data;
    logic pipe_act, lu_hs, drain, bypass, push, full, empty;
    wb_src_e src;
    assign pipe_act = pipe_we && pipe_waddr != '0;
    assign lu_hs = !rst && lu_valid && !full;
    assign drain = !pipe_act && !empty;
    assign bypass = !pipe_act && empty && lu_hs && lu_waddr != '0;
    // r0 results complete the handshake but are dropped here
    assign push = lu_hs && lu_waddr != '0 && !bypass;
    assign src = pipe_act ? SrcPipe : drain ? SrcFifo : bypass ? SrcBypass : SrcNone;
    assign lc_addr = drain ? head[AddrW+DataW-1:DataW] : lu_waddr;
    assign lc_data = drain ? head[DataW-1:0] : lu_wdata;
    sync_fifo #(.W(AddrW + DataW), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  ({lu_waddr, lu_wdata}),
        .pop_i  (drain),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    assign lu_ready = !rst && !full;
    assign rf_we = !rst && src != SrcNone;
    assign rf_waddr = (rst || src == SrcNone) ? '0 : src == SrcPipe ? pipe_waddr : lc_addr;
    assign rf_wdata = (rst || src == SrcNone) ? '0 : src == SrcPipe ? pipe_wdata : lc_data;
    assign busy1 = !rst && chk_addr1 != '0 && pending_q[chk_addr1];
    assign busy2 = !rst && chk_addr2 != '0 && pending_q[chk_addr2];
    assign stall_req = !rst && count_q == CW'(STARVE_MAX);
    always_comb begin
        pending_d = pending_q;
        if (drain || bypass) pending_d[lc_addr] = 1'b0;
        // a fresh issue outranks the commit of an older result to the same register
        if (issue_valid && issue_addr != '0) pending_d[issue_addr] = 1'b1;
        count_d = (empty || drain) ? '0 : (count_q == CW'(STARVE_MAX)) ? count_q : count_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            count_q <= '0;
        end else begin
            pending_q <= pending_d;
            count_q <= count_d;
        end
    end
endmodule
